// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_byte_serializer.sv
// Word load/shift register: presents the word MSB-first, one byte per shift,
// with a byte counter flagging the final byte of the word.
module imem_byte_serializer
    import imem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              last_byte_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // A load in the final-byte slot takes priority over the shift.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load_i) begin
            shift_d = word_i;
            idx_d   = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_o      = shift_q[WORD_W-1 -: BYTE_W];
    assign last_byte_o = (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit words into byte-wide instruction memory, big-endian.
// Optional running checksum of accepted words: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrap_err,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              wrap_pend_q, wrap_pend_d;
    logic              wrap_err_q, wrap_err_d;
    logic              load, shift, last_byte;

    // Ready comes from registered state only, never from in_valid.
    assign in_ready = (state_q == ACCEPT) || ((state_q == WRITE) && last_byte && !last_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        wrap_pend_d = wrap_pend_q;
        wrap_err_d  = wrap_err_q;
        load        = 1'b0;
        shift       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCEPT;
                    addr_d      = base_addr & ALIGN_MASK;
                    wrap_pend_d = 1'b0;
                    wrap_err_d  = 1'b0;
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    load    = 1'b1;
                    last_d  = in_last;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                shift  = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == '1) wrap_pend_d = 1'b1;
                if (wrap_pend_q)  wrap_err_d  = 1'b1;
                if (last_byte) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else if (in_valid) begin
                        load   = 1'b1;
                        last_d = in_last;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            wrap_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            wrap_pend_q <= wrap_pend_d;
            wrap_err_q  <= wrap_err_d;
        end
    end

    imem_byte_serializer u_ser (
        .clk_i       (clk),
        .rst_ni      (rst),
        .load_i      (load),
        .shift_i     (shift),
        .word_i      (in_word),
        .byte_o      (mem_wdata),
        .last_byte_o (last_byte)
    );

    assign mem_we   = (state_q == WRITE);
    assign mem_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign wrap_err = wrap_err_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
    logic        csum_clr;

    assign csum_clr = (state_q == IDLE) && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else if (csum_clr) begin
            csum_q <= '0;
        end else if (load) begin
            csum_q <= csum_q + in_word;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

- Write-side counterpart of the byte-addressed instruction memory.
- Accepts 32-bit program words on a valid/ready stream and writes each word as four bytes, big-endian, to consecutive addresses on the memory's byte write port. The most significant byte goes to the lowest address.
- Used at boot or under test to fill instruction storage before the core fetches from it.

## Interface
- ADDR_W, 8, byte address width; matches the fetch `pc` width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- base_addr  in  ADDR_W  first byte address; sampled on an accepted `start`; bits [1:0] are forced to 0.
- in_valid  in  1  `in_word` is valid.
- in_ready  out  1  loader accepts `in_word` this cycle.
- in_word  in  32  program word.
- in_last  in  1  qualifies the final word of the load; sampled with the word.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the load completes.
- wrap_err  out  1  sticky; set when the address wraps past 2^ADDR_W−1 and further bytes are written; cleared only by the next accepted `start`.
- checksum  out  32  sum of accepted words, modulo 2^32; see Configuration.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 → ACCEPT; address reg ← {base_addr[ADDR_W-1:2],2'b00}; wrap_err ← 0; checksum ← 0.
- ACCEPT:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_word` into the shift reg and `in_last` into a flag; byte_idx ← 0; go to WRITE.
- WRITE, one byte per cycle:
  - `mem_we`=1, `mem_addr`=addr, `mem_wdata`=shift[31:24].
  - At the clock edge: shift ← shift<<8; addr ← addr+1, wrapping modulo 2^ADDR_W; byte_idx ← byte_idx+1.
- Byte 3 (byte_idx==3):
  - If the last flag is set → DONE, and `in_ready`=0.
  - Otherwise `in_ready`=1, so the next word can be accepted in the same cycle for back-to-back writes.
  - If a word is accepted → stay in WRITE with byte_idx ← 0 and the new word loaded.
  - If no word is accepted → ACCEPT.
- Wrap: if addr == 2^ADDR_W−1 at a write and a further byte is written afterwards, set `wrap_err`. Writes continue at address 0; the loader does not abort.
- DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored; it has no effect on state or registers.
- `in_valid` outside ACCEPT or the byte-3 slot is not consumed. The source must hold the word until `in_ready`.

## Timing
- Reset values (asserted asynchronously, no clock needed): state=IDLE; `in_ready`, `mem_we`, `busy`, `done`, `wrap_err`=0; `mem_addr`=0; `mem_wdata`=0; `checksum`=0.
- Reset mid-load: the partial word is abandoned and no further `mem_we` pulses occur. Bytes already written stay in memory.
- All outputs are registered or decoded from state only; there is no combinational path from `in_valid` to any output.
- Latency: `start` at cycle 0 → `in_ready` at cycle 1.
- First byte write in the cycle after acceptance.
- Sustained throughput: 4 cycles per word.
- A single-word load takes 1 accept + 4 write cycles, then `done` in the following cycle.

## Configuration
- IMEM_LOADER_CHECKSUM_EN:
  - Defined: a 32-bit accumulator adds each accepted `in_word` (wrapping). `checksum` holds the total from the `done` pulse until the next accepted `start`.
  - Undefined: the accumulator is not built and `checksum` is tied to 0. The port remains present so the instantiating parent is unchanged.

## Structure
- Shared package `imem_pkg`: state enum (IDLE, ACCEPT, WRITE, DONE); WORD_BYTES=4; BYTE_W=8.
- One sub-module, `imem_byte_serializer`: a 32-bit load/shift register plus a 2-bit byte counter. It exposes `load`, `byte`, `last_byte`.
- The FSM, address counter, wrap detection and checksum stay in `imem_loader`.

## Test plan
- Reset: drive rst=0 mid-WRITE → all outputs drop to reset values the same cycle, with no clock edge required. After release, IDLE with `in_ready`=0.
- Single word: base_addr=0x10, word 0x8C020004, last=1 → writes 0x8C@0x10, 0x02@0x11, 0x00@0x12, 0x04@0x13. `done` one cycle after the 0x13 write.
- Back-to-back: 3 words with `in_valid` held high → 12 consecutive cycles of `mem_we`=1 with no gaps, at addresses base..base+11.
- Stall: `in_valid` drops for 5 cycles after word 1 → `mem_we`=0 and `in_ready`=1 during the gap. Word 2 then lands at base+4.
- Wrap: ADDR_W=8, base_addr=0xFC, 2 words → second word written at 0x00–0x03; `wrap_err`=1 and it stays set after `done`.
- Misaligned base/ignored start: base_addr=0x13 → first write at 0x10. A second `start` pulse while busy → no effect. With IMEM_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 → `checksum`=0x00000001.
